dds_sweep_controller: RTL and testbench

//  Sequences the DDS phase counter through a linear frequency sweep (chirp).

---
 rtl/dds_sweep_controller.sv | 135 +++++++++++++
 tb/tb_dds_sweep_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_controller.sv
// dds_sweep_controller: linear chirp sequencer for the DDS phase counter.
// Walks step_start..step_stop in step_inc increments, dwelling on each step.
module dds_sweep_controller #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DWELL_WIDTH   = 16,
  parameter int INITIAL_STEP  = 1,
  parameter bit SYNC_TO_ZERO  = 1'b0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] step_start,
  input  logic [ADDRESS_WIDTH-1:0] step_stop,
  input  logic [ADDRESS_WIDTH-1:0] step_inc,
  input  logic [DWELL_WIDTH-1:0]   dwell,
  input  logic                     zero_address,
  output logic                     SET,
  output logic [ADDRESS_WIDTH-1:0] step_out,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DWELL_WIDTH;

  localparam logic [AW-1:0] INIT = AW'(INITIAL_STEP);
  localparam logic [DW-1:0] ONE  = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DWELL,
    S_WAIT_ZERO,
    S_DONE
  } state_t;

  state_t        state, state_d;
  logic [AW-1:0] cur, cur_d;
  logic [AW-1:0] stop_r, stop_d;
  logic [AW-1:0] inc_r, inc_d;
  logic [DW-1:0] dwell_r, dwell_d;
  logic [DW-1:0] cnt, cnt_d;
  logic [AW:0]   sum;
  logic [AW-1:0] nxt;
  logic          last;
  logic          final_step;

  // Next step with one extra bit so a wrapping sum clamps to stop.
  always_comb begin
    sum        = {1'b0, cur} + {1'b0, inc_r};
    nxt        = (sum > {1'b0, stop_r}) ? stop_r : sum[AW-1:0];
    last       = (cnt == (dwell_r - ONE));
    final_step = (cur >= stop_r) || (inc_r == '0);
  end

  // Next-state and next-datapath decode; abort overrides everything.
  always_comb begin
    state_d = state;
    cur_d   = cur;
    stop_d  = stop_r;
    inc_d   = inc_r;
    dwell_d = dwell_r;
    cnt_d   = cnt;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_d   = step_start;
            stop_d  = step_stop;
            inc_d   = step_inc;
            dwell_d = (dwell == '0) ? ONE : dwell;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_d   = '0;
          state_d = S_DWELL;
        end
        S_DWELL: begin
          if (last) begin
            if (final_step) begin
              state_d = S_DONE;
            end else begin
              cur_d   = nxt;
              state_d = SYNC_TO_ZERO ? S_WAIT_ZERO : S_LOAD;
            end
          end else begin
            cnt_d = cnt + ONE;
          end
        end
        S_WAIT_ZERO: begin
          if (zero_address) state_d = S_LOAD;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; step_out loads as LOAD is entered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      cur      <= INIT;
      stop_r   <= '0;
      inc_r    <= '0;
      dwell_r  <= ONE;
      cnt      <= '0;
      step_out <= INIT;
    end else begin
      state   <= state_d;
      cur     <= cur_d;
      stop_r  <= stop_d;
      inc_r   <= inc_d;
      dwell_r <= dwell_d;
      cnt     <= cnt_d;
      if (state_d == S_LOAD) step_out <= cur_d;
    end
  end

  // Strobes decoded straight from the state register.
  always_comb begin
    SET  = (state == S_LOAD);
    done = (state == S_DONE);
    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// tb_dds_sweep_controller: directed sweeps with a SET/done scoreboard.
// dut0 retunes freely, dut1 waits for a phase-zero crossing.
module tb_dds_sweep_controller;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  step_start = '0;
  logic [7:0]  step_stop = '0;
  logic [7:0]  step_inc = '0;
  logic [15:0] dwell = '0;
  logic        zero0 = 1'b0;
  logic        zero1 = 1'b0;

  logic        SET0, busy0, done0;
  logic [7:0]  step_out0;
  logic        SET1, busy1, done1;
  logic [7:0]  step_out1;

  typedef struct packed {
    int        cyc;
    logic [7:0] step;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  qd0[$];
  int  qd1[$];

  int cyc = 0;
  int vec = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  dds_sweep_controller #(
    .ADDRESS_WIDTH(8),
    .DWELL_WIDTH(16),
    .INITIAL_STEP(1),
    .SYNC_TO_ZERO(1'b0)
  ) dut0 (
    .CLK(CLK),
    .RESET(RESET),
    .start(start0),
    .abort(abort),
    .step_start(step_start),
    .step_stop(step_stop),
    .step_inc(step_inc),
    .dwell(dwell),
    .zero_address(zero0),
    .SET(SET0),
    .step_out(step_out0),
    .busy(busy0),
    .done(done0)
  );

  dds_sweep_controller #(
    .ADDRESS_WIDTH(8),
    .DWELL_WIDTH(16),
    .INITIAL_STEP(3),
    .SYNC_TO_ZERO(1'b1)
  ) dut1 (
    .CLK(CLK),
    .RESET(RESET),
    .start(start1),
    .abort(abort),
    .step_start(step_start),
    .step_stop(step_stop),
    .step_inc(step_inc),
    .dwell(dwell),
    .zero_address(zero1),
    .SET(SET1),
    .step_out(step_out1),
    .busy(busy1),
    .done(done1)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    vec++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic monitor();
    ev_t  e;
    logic pd0 = 1'b0;
    logic pd1 = 1'b0;
    forever begin
      @(negedge CLK);
      if (pd0) check("busy0_after_done", 64'(busy0), 64'(0));
      if (pd1) check("busy1_after_done", 64'(busy1), 64'(0));
      pd0 = done0;
      pd1 = done1;
      if (SET0) begin
        check("set0_expected", 64'(q0.size() != 0), 64'(1));
        if (q0.size() != 0) begin
          e = q0.pop_front();
          check("set0_cyc_step", 64'({cyc, step_out0}),
                64'({e.cyc, e.step}));
        end
      end
      if (done0) begin
        check("done0_expected", 64'(qd0.size() != 0), 64'(1));
        if (qd0.size() != 0)
          check("done0_cyc", 64'(cyc), 64'(qd0.pop_front()));
      end
      if (SET1) begin
        check("set1_expected", 64'(q1.size() != 0), 64'(1));
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("set1_cyc_step", 64'({cyc, step_out1}),
                64'({e.cyc, e.step}));
        end
      end
      if (done1) begin
        check("done1_expected", 64'(qd1.size() != 0), 64'(1));
        if (qd1.size() != 0)
          check("done1_cyc", 64'(cyc), 64'(qd1.pop_front()));
      end
    end
  endtask

  // Starts dut0 and queues at most nmax expected SETs (+done if all fit).
  task automatic sweep0(input logic [7:0] s, input logic [7:0] p,
                        input logic [7:0] i, input logic [15:0] d,
                        input int nmax);
    int       c;
    int       dd;
    int       n;
    int       cur;
    int       nx;
    bit       fin;
    step_start = s;
    step_stop  = p;
    step_inc   = i;
    dwell      = d;
    start0     = 1'b1;
    dd  = (d == 0) ? 1 : int'(d);
    c   = cyc + 1;
    cur = int'(s);
    n   = 0;
    fin = 1'b0;
    while (!fin && n < nmax) begin
      q0.push_back('{cyc: c, step: cur[7:0]});
      n++;
      if (cur >= int'(p) || i == 0) begin
        fin = 1'b1;
      end else begin
        nx  = cur + int'(i);
        cur = (nx > int'(p)) ? int'(p) : nx;
        c   = c + dd + 1;
      end
    end
    if (fin) qd0.push_back(c + dd + 1);
    cycles(1);
    start0     = 1'b0;
    step_start = 8'hA5;
    step_stop  = 8'h00;
    step_inc   = 8'h01;
    dwell      = 16'd0;
  endtask

  task automatic drain(input string tag);
    check({tag, "_q0"}, 64'(q0.size() + qd0.size()), 64'(0));
    check({tag, "_q1"}, 64'(q1.size() + qd1.size()), 64'(0));
  endtask

  initial begin
    int c;
    fork
      monitor();
    join_none

    cycles(3);
    @(negedge CLK);
    check("rst_set0", 64'(SET0), 64'(0));
    check("rst_busy0", 64'(busy0), 64'(0));
    check("rst_done0", 64'(done0), 64'(0));
    check("rst_step0", 64'(step_out0), 64'(1));
    check("rst_step1", 64'(step_out1), 64'(3));
    check("rst_busy1", 64'(busy1), 64'(0));
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    cycles(2);

    // Test 1: 10..40 by 10, dwell 3; start while busy is ignored.
    sweep0(8'd10, 8'd40, 8'd10, 16'd3, 99);
    cycles(3);
    step_start = 8'd99;
    start0 = 1'b1;
    cycles(1);
    start0 = 1'b0;
    cycles(20);
    drain("t1");
    check("t1_step_held", 64'(step_out0), 64'(40));

    // Test 2: clamped final step, dwell 0 acts as 1.
    sweep0(8'd10, 8'd30, 8'd7, 16'd0, 99);
    cycles(15);
    drain("t2");

    // Test 3: 8-bit overflow clamps; start >= stop; inc 0.
    sweep0(8'd250, 8'd255, 8'd10, 16'd5, 99);
    cycles(20);
    drain("t3a");
    sweep0(8'd50, 8'd20, 8'd4, 16'd1, 99);
    cycles(8);
    drain("t3b");
    sweep0(8'd7, 8'd9, 8'd0, 16'd2, 99);
    cycles(8);
    drain("t3c");

    // Test 4: sync-to-zero holds the second retune.
    step_start = 8'd5;
    step_stop  = 8'd15;
    step_inc   = 8'd10;
    dwell      = 16'd2;
    start1     = 1'b1;
    q1.push_back('{cyc: cyc + 1, step: 8'd5});
    cycles(1);
    start1 = 1'b0;
    cycles(20);
    check("t4_wait_q1", 64'(q1.size()), 64'(0));
    check("t4_busy1", 64'(busy1), 64'(1));
    zero1 = 1'b1;
    c = cyc;
    q1.push_back('{cyc: c + 1, step: 8'd15});
    qd1.push_back(c + 4);
    cycles(1);
    zero1 = 1'b0;
    cycles(10);
    drain("t4");

    // Test 5: abort after SET(20), start raised alongside is ignored.
    sweep0(8'd10, 8'd40, 8'd10, 16'd3, 2);
    cycles(5);
    abort  = 1'b1;
    start0 = 1'b1;
    cycles(1);
    abort  = 1'b0;
    start0 = 1'b0;
    @(negedge CLK);
    check("t5_busy0", 64'(busy0), 64'(0));
    check("t5_step0", 64'(step_out0), 64'(20));
    @(posedge CLK);
    #1;
    cycles(20);
    drain("t5a");
    check("t5_step_kept", 64'(step_out0), 64'(20));
    sweep0(8'd10, 8'd40, 8'd10, 16'd3, 99);
    cycles(22);
    drain("t5b");

    // Test 6: one-cycle reset mid-sweep.
    sweep0(8'd10, 8'd40, 8'd10, 16'd3, 1);
    cycles(2);
    RESET = 1'b1;
    cycles(1);
    RESET = 1'b0;
    @(negedge CLK);
    check("t6_set0", 64'(SET0), 64'(0));
    check("t6_busy0", 64'(busy0), 64'(0));
    check("t6_step0", 64'(step_out0), 64'(1));
    @(posedge CLK);
    #1;
    cycles(20);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

endmodule
